// File: rtl/raytracing_line_collector.sv
// Collects the interleaved per-worker colour buffers of one line and streams them to the framebuffer in ascending x.
// Optional build macro LINE_COLLECTOR_CHECKSUM_EN adds a 16-bit running sum of written pixels (line_checksum).
module raytracing_line_collector #(
    parameter int N_WORKERS        = 10,
    parameter int JOBS_SUBDIVISION = 64,
    parameter int COLOR_B          = 12,
    parameter int LINE_W           = 640,
    parameter int FB_ADDR_B        = 19
) (
    input  logic                                           clk,
    input  logic                                           rst_,
    input  logic                                           line_start,
    input  logic [8:0]                                     line_y,
    input  logic [N_WORKERS-1:0]                           worker_busy,
    input  logic [N_WORKERS*JOBS_SUBDIVISION*COLOR_B-1:0]  worker_buffers,
    output logic                                           fb_we,
    output logic [FB_ADDR_B-1:0]                           fb_addr,
    output logic [COLOR_B-1:0]                             fb_data,
    input  logic                                           fb_ready,
    output logic                                           line_done,
    output logic                                           collecting,
`ifdef LINE_COLLECTOR_CHECKSUM_EN
    output logic [15:0]                                    line_checksum,
`endif
    output logic                                           overrun
);

    localparam int WI_B = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
    localparam int JI_B = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;

    generate
        if (LINE_W != N_WORKERS * JOBS_SUBDIVISION) begin : g_bad_line_w
            $error("LINE_W must equal N_WORKERS*JOBS_SUBDIVISION");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, ARM, WAIT, WRITE, DONE} state_t;

    state_t                 state;
    logic [N_WORKERS-1:0]   seen;
    logic [WI_B-1:0]        wi, nxt_w, sel_w;
    logic [JI_B-1:0]        ji, nxt_j, sel_j;
    logic [FB_ADDR_B-1:0]   addr_base;
    logic                   last_w, last_j, xfer, accept_line;
    logic [COLOR_B-1:0]     colors [N_WORKERS][JOBS_SUBDIVISION];

    for (genvar w = 0; w < N_WORKERS; w++) begin : g_w
        for (genvar j = 0; j < JOBS_SUBDIVISION; j++) begin : g_j
            assign colors[w][j] = worker_buffers[(w*JOBS_SUBDIVISION+j)*COLOR_B +: COLOR_B];
        end
    end

    // On a transfer the next pixel is fetched so fb_data is ready the following cycle.
    always_comb begin
        last_w      = (wi == WI_B'(N_WORKERS-1));
        last_j      = (ji == JI_B'(JOBS_SUBDIVISION-1));
        nxt_w       = last_w ? '0 : wi + WI_B'(1);
        nxt_j       = last_w ? ji + JI_B'(1) : ji;
        xfer        = (state == WRITE) && fb_we && fb_ready;
        accept_line = ((state == IDLE) || (state == DONE)) && line_start;
        sel_w       = xfer ? nxt_w : wi;
        sel_j       = xfer ? nxt_j : ji;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            seen       <= '0;
            wi         <= '0;
            ji         <= '0;
            addr_base  <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            line_done  <= 1'b0;
            collecting <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            line_done <= 1'b0;
            overrun   <= line_start && collecting;
            case (state)
                // DONE accepts a new line like IDLE since collecting is already low there.
                IDLE, DONE: begin
                    state <= IDLE;
                    if (line_start) begin
                        addr_base  <= FB_ADDR_B'(line_y) * FB_ADDR_B'(LINE_W);
                        seen       <= '0;
                        wi         <= '0;
                        ji         <= '0;
                        collecting <= 1'b1;
                        state      <= ARM;
                    end
                end
                ARM: begin
                    seen <= seen | worker_busy;
                    if ((seen | worker_busy) == '1)
                        state <= WAIT;
                end
                WAIT: begin
                    if (worker_busy == '0)
                        state <= WRITE;
                end
                WRITE: begin
                    if (!fb_we) begin
                        fb_we   <= 1'b1;
                        fb_addr <= addr_base;
                        fb_data <= colors[sel_w][sel_j];
                    end else if (fb_ready) begin
                        if (last_w && last_j) begin
                            fb_we      <= 1'b0;
                            collecting <= 1'b0;
                            line_done  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            wi      <= nxt_w;
                            ji      <= nxt_j;
                            fb_addr <= fb_addr + FB_ADDR_B'(1);
                            fb_data <= colors[sel_w][sel_j];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINE_COLLECTOR_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            line_checksum <= '0;
        else if (accept_line)
            line_checksum <= '0;
        else if (xfer)
            line_checksum <= line_checksum + 16'(fb_data);
    end
`endif

endmodule

// File: tb/tb_raytracing_line_collector.sv
// Bench for raytracing_line_collector: table of line scenarios plus hand sequences, checked against a pixel-order model.
module tb_raytracing_line_collector;

    localparam int N  = 10;
    localparam int J  = 64;
    localparam int CB = 12;
    localparam int LW = 640;
    localparam int AB = 19;

    logic                 clk = 1'b0;
    logic                 rst_ = 1'b0;
    logic                 line_start = 1'b0;
    logic [8:0]           line_y = '0;
    logic [N-1:0]         worker_busy = '0;
    logic [N*J*CB-1:0]    worker_buffers = '0;
    logic                 fb_we;
    logic [AB-1:0]        fb_addr;
    logic [CB-1:0]        fb_data;
    logic                 fb_ready = 1'b0;
    logic                 line_done;
    logic                 collecting;
    logic                 overrun;
`ifdef LINE_COLLECTOR_CHECKSUM_EN
    logic [15:0]          line_checksum;
`endif

    raytracing_line_collector dut (
        .clk            (clk),
        .rst_           (rst_),
        .line_start     (line_start),
        .line_y         (line_y),
        .worker_busy    (worker_busy),
        .worker_buffers (worker_buffers),
        .fb_we          (fb_we),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .fb_ready       (fb_ready),
        .line_done      (line_done),
        .collecting     (collecting),
`ifdef LINE_COLLECTOR_CHECKSUM_EN
        .line_checksum  (line_checksum),
`endif
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        int pre;
        int busy;
        bit rnd;
        bit stagger;
        int ovr_at;
        int buf_mode;
        int exp_first;
        int exp_last;
    } vec_t;

    typedef struct {
        int         addr;
        logic [11:0] data;
    } pix_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] bufmem [N][J];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int w = 0; w < N; w++)
            for (int j = 0; j < J; j++) begin
                int x;
                x = w + N*j;
                case (mode)
                    0:       bufmem[w][j] = 12'(x);
                    2:       bufmem[w][j] = 12'hFFF;
                    default: bufmem[w][j] = 12'($urandom);
                endcase
                worker_buffers[(w*J+j)*CB +: CB] = bufmem[w][j];
            end
    endtask

    task automatic run_line(input vec_t v, input bit started, input int chain_y);
        pix_t        exp_q[$];
        pix_t        e;
        int          drop[N];
        int          last_drop, nwr, lat, nd, novr, hold_err, early_we, cyc, first_a, last_a;
        bit          done_seen, ovr_sent;
        logic        p_we, p_rdy;
        logic [AB-1:0] p_addr;
        logic [CB-1:0] p_data;
        logic [15:0] sum;

        // Expected stream: pixels in ascending x, colour taken from worker x%N, job x/N.
        for (int x = 0; x < LW; x++) begin
            e.addr = v.y*LW + x;
            e.data = bufmem[x % N][x / N];
            exp_q.push_back(e);
        end

        early_we = 0;
        if (!started) begin
            line_y     = 9'(v.y);
            line_start = 1'b1;
            tick();
            line_start = 1'b0;
        end
        for (int c = 0; c < v.pre; c++) begin
            worker_busy = '0;
            fb_ready    = 1'($urandom_range(0, 1));
            tick();
            if (fb_we) early_we++;
        end
        last_drop = 0;
        for (int w = 0; w < N; w++) begin
            drop[w] = v.busy + (v.stagger ? int'($urandom_range(0, 6)) : 0);
            if (drop[w] > last_drop) last_drop = drop[w];
        end
        for (int c = 0; c < last_drop; c++) begin
            for (int w = 0; w < N; w++) worker_busy[w] = (c < drop[w]);
            fb_ready = 1'($urandom_range(0, 1));
            tick();
            if (fb_we) early_we++;
        end
        worker_busy = '0;

        p_we = fb_we; p_addr = fb_addr; p_data = fb_data;
        p_rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        fb_ready = p_rdy;
        lat = -1; nwr = 0; nd = 0; novr = 0; hold_err = 0; cyc = 0;
        first_a = -1; last_a = -1; sum = '0; done_seen = 0; ovr_sent = 0;
        while (!done_seen && cyc < 5000) begin
            tick();
            cyc++;
            if (fb_we && lat < 0) lat = cyc;
            if (p_we && p_rdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_write", nwr, LW - 1);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_addr", p_addr, e.addr);
                    check("pix_data", p_data, e.data);
                end
                if (nwr == 0) first_a = int'(p_addr);
                last_a = int'(p_addr);
                nwr++;
                sum = sum + 16'(p_data);
            end else if (p_we) begin
                if (!fb_we || fb_addr != p_addr || fb_data != p_data) hold_err++;
            end
            if (overrun) novr++;
            if (line_done) begin
                nd++;
                done_seen = 1;
            end
            line_start = 1'b0;
            if (v.ovr_at >= 0 && nwr == v.ovr_at && !ovr_sent) begin
                line_start = 1'b1;
                line_y     = 9'd33;
                ovr_sent   = 1;
            end
            p_we = fb_we; p_addr = fb_addr; p_data = fb_data;
            p_rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            fb_ready = p_rdy;
        end

        check("line_done_seen", done_seen, 1);
        check("collecting_at_done", collecting, 0);
        check("we_at_done", fb_we, 0);
        check("writes", nwr, LW);
        check("first_addr", first_a, v.exp_first);
        check("last_addr", last_a, v.exp_last);
        check("first_latency", lat, 2);
        check("hold_stable", hold_err, 0);
        check("early_we", early_we, 0);
        check("overrun_pulses", novr, (v.ovr_at >= 0) ? 1 : 0);
`ifdef LINE_COLLECTOR_CHECKSUM_EN
        check("checksum", line_checksum, sum);
        if (v.buf_mode == 2) check("checksum_fff", line_checksum, 16'hFD80); // 640*4095 mod 2^16
`endif

        if (chain_y >= 0) begin
            line_y     = 9'(chain_y);
            line_start = 1'b1;
        end
        tick();
        line_start = 1'b0;
        check("line_done_one_cycle", line_done, 0);
        check("collecting_after", collecting, (chain_y >= 0) ? 1 : 0);
        check("overrun_after", overrun, 0);
        check("we_after", fb_we, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t hv;
        int   reached;

        vecs[0] = '{y: 5,   pre: 0, busy: 20, rnd: 0, stagger: 0, ovr_at: -1,  buf_mode: 0, exp_first: 3200,   exp_last: 3839};
        vecs[1] = '{y: 0,   pre: 0, busy: 5,  rnd: 1, stagger: 1, ovr_at: -1,  buf_mode: 1, exp_first: 0,      exp_last: 639};
        vecs[2] = '{y: 12,  pre: 3, busy: 10, rnd: 0, stagger: 0, ovr_at: -1,  buf_mode: 1, exp_first: 7680,   exp_last: 8319};
        vecs[3] = '{y: 200, pre: 0, busy: 4,  rnd: 1, stagger: 0, ovr_at: 100, buf_mode: 1, exp_first: 128000, exp_last: 128639};
        vecs[4] = '{y: 300, pre: 0, busy: 3,  rnd: 1, stagger: 1, ovr_at: -1,  buf_mode: 2, exp_first: 192000, exp_last: 192639};
        vecs[5] = '{y: 479, pre: 1, busy: 1,  rnd: 0, stagger: 0, ovr_at: -1,  buf_mode: 1, exp_first: 306560, exp_last: 307199};

        repeat (3) tick();
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_line_done", line_done, 0);
        check("rst_collecting", collecting, 0);
        check("rst_overrun", overrun, 0);
        rst_ = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            fill(vecs[i].buf_mode);
            run_line(vecs[i], 1'b0, -1);
            repeat (2) tick();
        end

        // line_start coinciding with line_done starts the next line immediately
        fill(1);
        hv = '{y: 20, pre: 0, busy: 2, rnd: 1, stagger: 0, ovr_at: -1, buf_mode: 1, exp_first: 12800, exp_last: 13439};
        run_line(hv, 1'b0, 21);
        hv = '{y: 21, pre: 0, busy: 2, rnd: 0, stagger: 1, ovr_at: -1, buf_mode: 1, exp_first: 13440, exp_last: 14079};
        run_line(hv, 1'b1, -1);

        // Reset in the middle of a line, then a fresh line on the last row
        fill(1);
        line_y = 9'd7; line_start = 1'b1; tick(); line_start = 1'b0;
        worker_busy = '1; repeat (3) tick(); worker_busy = '0; fb_ready = 1'b1;
        reached = 0;
        for (int c = 0; c < 2000 && !reached; c++) begin
            tick();
            if (fb_we && fb_addr == AB'(7*LW + 300)) reached = 1;
        end
        check("reached_pixel300", reached, 1);
        #2 rst_ = 1'b0;
        #1;
        check("midrst_fb_we", fb_we, 0);
        check("midrst_line_done", line_done, 0);
        check("midrst_collecting", collecting, 0);
        repeat (2) tick();
        rst_ = 1'b1;
        fb_ready = 1'b0;
        repeat (3) tick();
        check("postrst_line_done", line_done, 0);
        check("postrst_fb_we", fb_we, 0);
        fill(1);
        hv = '{y: 479, pre: 0, busy: 6, rnd: 1, stagger: 1, ovr_at: -1, buf_mode: 1, exp_first: 306560, exp_last: 307199};
        run_line(hv, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
